// File: rtl/tracker_pkg.sv
// Shared types and widths for the orange-pixel centroid tracker and downstream steering logic.
package tracker_pkg;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CNT_W = 19;
  localparam int unsigned SUM_W = 28;

  typedef enum logic [1:0] {
    DIR_NONE   = 2'b00,
    DIR_LEFT   = 2'b01,
    DIR_RIGHT  = 2'b10,
    DIR_CENTRE = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_ACCUM,
    ST_EVAL,
    ST_COMMIT
  } state_t;

  // Per-frame accumulator payload
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum_x;
    logic [X_W-1:0]   xmin;
    logic [X_W-1:0]   xmax;
    logic [Y_W-1:0]   ymin;
    logic [Y_W-1:0]   ymax;
  } stats_t;

  // Empty-frame value: mins all-ones, maxes zero so the first pixel wins both compares
  function automatic stats_t clear_stats();
    stats_t s;
    s.count = '0;
    s.sum_x = '0;
    s.xmin  = '1;
    s.xmax  = '0;
    s.ymin  = '1;
    s.ymax  = '0;
    return s;
  endfunction

endpackage

// File: rtl/orange_centroid_tracker_if.sv
// Pixel-stream inputs and per-frame result outputs of the centroid tracker.
interface orange_centroid_tracker_if;
  import tracker_pkg::*;

  logic             active;
  logic             vsync;
  logic             is_orange;
  dir_t             direction;
  logic             detected;
  logic [CNT_W-1:0] pixel_count;
  logic [X_W-1:0]   bbox_xmin;
  logic [X_W-1:0]   bbox_xmax;
  logic [Y_W-1:0]   bbox_ymin;
  logic [Y_W-1:0]   bbox_ymax;
  logic             frame_valid;

  modport master (
    output active, vsync, is_orange,
    input  direction, detected, pixel_count,
    input  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, frame_valid
  );

  modport slave (
    input  active, vsync, is_orange,
    output direction, detected, pixel_count,
    output bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, frame_valid
  );

endinterface

// File: rtl/pixel_position_counter.sv
// Derives saturating pixel x/y coordinates and the frame-end strobe from VGA active/vsync.
module pixel_position_counter
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           active,
  input  logic           vsync,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_end_c
);

  logic active_d;
  logic vsync_d;
  logic line_end_c;

  assign frame_end_c = vsync_d & ~vsync;
  assign line_end_c  = active_d & ~active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_d <= 1'b0;
      vsync_d  <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      active_d <= active;
      vsync_d  <= vsync;

      if (active) begin
        if (x != X_W'(H_ACTIVE - 1)) x <= x + X_W'(1);
      end else if (line_end_c) begin
        x <= '0;
      end

      if (frame_end_c) begin
        y <= '0;
      end else if (line_end_c && (y != Y_W'(V_ACTIVE - 1))) begin
        y <= y + Y_W'(1);
      end
    end
  end

endmodule

// File: rtl/orange_centroid_tracker.sv
// Per-frame orange-pixel statistics, left/centre/right classification and multi-frame debounce.
module orange_centroid_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned MIN_PIXELS     = 200,
  parameter int unsigned LEFT_BOUND     = 213,
  parameter int unsigned RIGHT_BOUND    = 427,
  parameter int unsigned CONFIRM_FRAMES = 3
) (
  input logic                      clk,
  input logic                      rst,
  orange_centroid_tracker_if.slave bus
);

  localparam int unsigned RUN_W = $clog2(CONFIRM_FRAMES + 1);

  state_t           state;
  state_t           state_nxt;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [Y_W-1:0]   y_px_c;
  logic             frame_end_c;
  logic             clear_c;
  logic             accum_en_c;
  stats_t           acc;
  stats_t           acc_nxt_c;
  stats_t           snap;
  dir_t             raw;
  dir_t             raw_c;
  dir_t             last_raw;
  dir_t             dir_nxt_c;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt_c;
  logic [SUM_W-1:0] left_lim_c;
  logic [SUM_W-1:0] right_lim_c;

  pixel_position_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .active      (bus.active),
    .vsync       (bus.vsync),
    .x           (x),
    .y           (y),
    .frame_end_c (frame_end_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SYNC;
    else     state <= state_nxt;
  end

  // Frame ends arriving in EVAL/COMMIT are ignored
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SYNC:   if (frame_end_c) state_nxt = ST_ACCUM;
      ST_ACCUM:  if (frame_end_c) state_nxt = ST_EVAL;
      ST_EVAL:   state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_ACCUM;
      default:   state_nxt = ST_SYNC;
    endcase
  end

  // A pixel coincident with frame end starts the new frame on row 0
  always_comb begin
    clear_c    = frame_end_c && ((state == ST_SYNC) || (state == ST_ACCUM));
    accum_en_c = (state != ST_SYNC) || frame_end_c;
    y_px_c     = frame_end_c ? '0 : y;
    acc_nxt_c  = clear_c ? clear_stats() : acc;
    if (accum_en_c && bus.active && bus.is_orange) begin
      acc_nxt_c.count = acc_nxt_c.count + CNT_W'(1);
      acc_nxt_c.sum_x = acc_nxt_c.sum_x + SUM_W'(x);
      if (x < acc_nxt_c.xmin)      acc_nxt_c.xmin = x;
      if (x > acc_nxt_c.xmax)      acc_nxt_c.xmax = x;
      if (y_px_c < acc_nxt_c.ymin) acc_nxt_c.ymin = y_px_c;
      if (y_px_c > acc_nxt_c.ymax) acc_nxt_c.ymax = y_px_c;
    end
  end

  // Centroid thirds compared as sum_x against count*bound, avoiding a divider
  always_comb begin
    left_lim_c  = SUM_W'(snap.count) * SUM_W'(LEFT_BOUND);
    right_lim_c = SUM_W'(snap.count) * SUM_W'(RIGHT_BOUND);
    if (snap.count < CNT_W'(MIN_PIXELS))  raw_c = DIR_NONE;
    else if (snap.sum_x < left_lim_c)     raw_c = DIR_LEFT;
    else if (snap.sum_x > right_lim_c)    raw_c = DIR_RIGHT;
    else                                  raw_c = DIR_CENTRE;
  end

  always_comb begin
    if (raw != last_raw)                          run_nxt_c = RUN_W'(1);
    else if (run_cnt == RUN_W'(CONFIRM_FRAMES))   run_nxt_c = run_cnt;
    else                                          run_nxt_c = run_cnt + RUN_W'(1);
    dir_nxt_c = (run_nxt_c == RUN_W'(CONFIRM_FRAMES)) ? raw : bus.direction;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= clear_stats();
      snap            <= clear_stats();
      raw             <= DIR_NONE;
      last_raw        <= DIR_NONE;
      run_cnt         <= '0;
      bus.direction   <= DIR_NONE;
      bus.detected    <= 1'b0;
      bus.pixel_count <= '0;
      bus.bbox_xmin   <= '1;
      bus.bbox_xmax   <= '0;
      bus.bbox_ymin   <= '1;
      bus.bbox_ymax   <= '0;
      bus.frame_valid <= 1'b0;
    end else begin
      acc             <= acc_nxt_c;
      bus.frame_valid <= (state == ST_EVAL);
      if ((state == ST_ACCUM) && frame_end_c) snap <= acc;
      if (state == ST_EVAL) raw <= raw_c;
      if (state == ST_COMMIT) begin
        run_cnt         <= run_nxt_c;
        last_raw        <= raw;
        bus.direction   <= dir_nxt_c;
        bus.detected    <= (dir_nxt_c != DIR_NONE);
        bus.pixel_count <= snap.count;
        bus.bbox_xmin   <= snap.xmin;
        bus.bbox_xmax   <= snap.xmax;
        bus.bbox_ymin   <= snap.ymin;
        bus.bbox_ymax   <= snap.ymax;
      end
    end
  end

endmodule

// File: tb/tb_orange_centroid_tracker.sv
// Directed frame-level bench for orange_centroid_tracker on a reduced 48x24 frame geometry.
module tb_orange_centroid_tracker;
  import tracker_pkg::*;

  localparam int unsigned H  = 48;
  localparam int unsigned V  = 24;
  localparam int unsigned MP = 20;
  localparam int unsigned LB = 16;
  localparam int unsigned RB = 32;
  localparam int unsigned CF = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fv_cnt = 0;

  always #5 clk = ~clk;

  orange_centroid_tracker_if bus ();

  orange_centroid_tracker #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .MIN_PIXELS     (MP),
    .LEFT_BOUND     (LB),
    .RIGHT_BOUND    (RB),
    .CONFIRM_FRAMES (CF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_line(input int y, input int bx0, input int bx1, input int by0, input int by1);
    for (int x = 0; x < int'(H); x++) begin
      @(negedge clk);
      bus.active    = 1'b1;
      bus.is_orange = (x >= bx0) && (x <= bx1) && (y >= by0) && (y <= by1);
    end
    @(negedge clk);
    bus.active    = 1'b0;
    bus.is_orange = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_vblank();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.vsync = (i >= 3);
    end
  endtask

  task automatic run_frame(input string tag, input int bx0, input int bx1, input int by0,
                           input int by1, input int cnt, input int xmin, input int xmax,
                           input int ymin, input int ymax, input int dir);
    int fv0;
    fv0 = fv_cnt;
    for (int y = 0; y < int'(V); y++) drive_line(y, bx0, bx1, by0, by1);
    drive_vblank();
    check_eq({tag, ".fv"},    32'(fv_cnt - fv0), 32'd1);
    check_eq({tag, ".count"}, 32'(bus.pixel_count), 32'(cnt));
    check_eq({tag, ".xmin"},  32'(bus.bbox_xmin), 32'(xmin));
    check_eq({tag, ".xmax"},  32'(bus.bbox_xmax), 32'(xmax));
    check_eq({tag, ".ymin"},  32'(bus.bbox_ymin), 32'(ymin));
    check_eq({tag, ".ymax"},  32'(bus.bbox_ymax), 32'(ymax));
    check_eq({tag, ".dir"},   32'(bus.direction), 32'(dir));
    check_eq({tag, ".det"},   32'(bus.detected), 32'(dir != 0));
  endtask

  initial begin
    int fv0;
    rst           = 1'b1;
    bus.active    = 1'b0;
    bus.vsync     = 1'b1;
    bus.is_orange = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst.dir",   32'(bus.direction), 32'd0);
    check_eq("rst.det",   32'(bus.detected), 32'd0);
    check_eq("rst.count", 32'(bus.pixel_count), 32'd0);
    check_eq("rst.fv",    32'(bus.frame_valid), 32'd0);
    check_eq("rst.xmin",  32'(bus.bbox_xmin), 32'd1023);
    check_eq("rst.xmax",  32'(bus.bbox_xmax), 32'd0);
    check_eq("rst.ymin",  32'(bus.bbox_ymin), 32'd511);
    check_eq("rst.ymax",  32'(bus.bbox_ymax), 32'd0);

    // First frame end only leaves SYNC
    drive_vblank();
    check_eq("sync.fv", 32'(fv_cnt), 32'd0);

    for (int i = 0; i < 3; i++) run_frame("empty", 1, 0, 1, 0, 0, 1023, 0, 511, 0, 0);
    check_eq("empty.fv_total", 32'(fv_cnt), 32'd3);

    // Left block: x 4..8, y 10..14 -> sum_x 150 < 25*16
    run_frame("left1", 4, 8, 10, 14, 25, 4, 8, 10, 14, 0);
    run_frame("left2", 4, 8, 10, 14, 25, 4, 8, 10, 14, 0);
    run_frame("left3", 4, 8, 10, 14, 25, 4, 8, 10, 14, 1);

    // Right block: x 40..44 -> sum_x 1050 > 25*32
    run_frame("right1", 40, 44, 10, 14, 25, 40, 44, 10, 14, 1);
    run_frame("right2", 40, 44, 10, 14, 25, 40, 44, 10, 14, 1);
    run_frame("right3", 40, 44, 10, 14, 25, 40, 44, 10, 14, 2);

    // Centre block: x 22..26 -> sum_x 600 within [400,800]; two frames do not confirm
    run_frame("centre1", 22, 26, 10, 14, 25, 22, 26, 10, 14, 2);
    run_frame("centre2", 22, 26, 10, 14, 25, 22, 26, 10, 14, 2);

    // 16 pixels, below the 20-pixel minimum
    run_frame("small1", 22, 25, 10, 13, 16, 22, 25, 10, 13, 2);
    run_frame("small2", 22, 25, 10, 13, 16, 22, 25, 10, 13, 2);
    run_frame("small3", 22, 25, 10, 13, 16, 22, 25, 10, 13, 0);

    // Reset mid-frame with orange present: remainder of that frame is not reported
    fv0 = fv_cnt;
    for (int y = 0; y < 12; y++) drive_line(y, 0, 47, 0, 23);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int y = 12; y < int'(V); y++) drive_line(y, 0, 47, 0, 23);
    drive_vblank();
    check_eq("midrst.fv", 32'(fv_cnt - fv0), 32'd0);
    check_eq("midrst.dir", 32'(bus.direction), 32'd0);

    run_frame("post_rst", 4, 8, 10, 14, 25, 4, 8, 10, 14, 0);

    // Full screen: 1152 pixels, sum_x 27072 within [18432,36864]
    run_frame("full1", 0, 47, 0, 23, 1152, 0, 47, 0, 23, 0);
    run_frame("full2", 0, 47, 0, 23, 1152, 0, 47, 0, 23, 0);
    run_frame("full3", 0, 47, 0, 23, 1152, 0, 47, 0, 23, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
